// File: rtl/if_id_skid.sv
// ---------------------------------------------------------------------------
// if_id_skid -- two-entry elastic buffer between instruction fetch and decode.
//
// Carries a DW-bit payload (PC + instruction word) under valid/ready. Sustains
// one transfer per cycle; in_ready depends only on occupancy state and rst, so
// decode back-pressure (out_ready) never reaches fetch combinationally.
//
// Ports:
//   clk        single clock, rising-edge
//   rst        synchronous, active-high reset (priority over flush)
//   flush      discard all buffered entries (branch/trap redirect)
//   in_valid   fetch presents a payload
//   in_ready   buffer accepts a payload this cycle
//   in_data    payload from fetch
//   out_valid  head entry is valid
//   out_ready  decode takes the head entry this cycle
//   out_data   head entry payload
//   count      occupancy 0..2
//
// Build option:
//   RISCX_SKID_FLUSH_EN  when defined, flush empties the buffer; when
//                        undefined the flush port is present but ignored.
// ---------------------------------------------------------------------------
module if_id_skid #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    // Occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          flush_eff;
    logic          push;
    logic          pop;

`ifdef RISCX_SKID_FLUSH_EN
    assign flush_eff = flush;
`else
    // Port kept for a uniform interface; masked so it has no effect.
    assign flush_eff = flush & 1'b0;
`endif

    // Outputs come from state and storage only: no in_* -> out_* path and
    // no out_ready -> in_ready path.
    assign in_ready  = (state != FULL) & ~rst;
    assign out_valid = (state != EMPTY);
    assign out_data  = mem[rd_ptr];
    assign count     = state;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush_eff) begin
            // Drops anything offered this cycle; storage keeps stale data,
            // which is harmless since out_valid is low.
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case (state)
                EMPTY: if (push) state <= ONE;
                ONE: begin
                    if (push && !pop)      state <= FULL;
                    else if (pop && !push) state <= EMPTY;
                end
                FULL:    if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_skid.sv
module tb_if_id_skid;

    localparam int DW = 64;
`ifdef RISCX_SKID_FLUSH_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    count;

    if_id_skid #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Scoreboard of payloads expected at out_data, in order.
    logic [DW-1:0] q[$];
    logic          acc = 1'b0;      // model: offer accepted at the coming edge
    logic          pend = 1'b0;     // an unaccepted offer is outstanding
    logic [DW-1:0] pend_data = '0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the model on every falling edge and
    // retires the head entry when decode takes it.
    always @(negedge clk) begin
        int sz;
        logic fl;
        sz = q.size();
        fl = flush & FE;
        chk("count", DW'(count), DW'(sz));
        chk("out_valid", DW'(out_valid), DW'(sz != 0));
        chk("in_ready", DW'(in_ready), DW'((sz != 2) && !rst));
        if (sz != 0) chk("out_data", out_data, q[0]);
        // Producer must hold its offer until accepted (redirect/reset exempt).
        if (pend && !rst && !flush) chk("producer_hold", DW'(in_valid) ^ in_data, DW'(1'b1) ^ pend_data);
        acc = in_valid && !rst && !fl && (sz != 2);
        pend = in_valid && !acc && !rst && !flush;
        pend_data = in_data;
        if (out_ready && sz != 0 && !rst && !fl) void'(q.pop_front());
    end

    // Scoreboard feed: records accepted stimulus at the edge it is taken.
    always @(posedge clk) begin
        if (rst || (flush && FE)) q.delete();
        else if (acc) q.push_back(in_data);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic v, input logic [DW-1:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        step();
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_data", out_data, '0);
        chk("rst_count", DW'(count), '0);
        step();

        // Back-to-back stream with decode always ready.
        offer(1'b1, 64'h1000_0001, 1'b1);
        offer(1'b1, 64'h1000_0002, 1'b1);
        offer(1'b1, 64'h1000_0003, 1'b1);
        offer(1'b0, 64'h0, 1'b1);
        step(2);

        // Fill, stall C while full, then drain A, B, C.
        offer(1'b1, 64'hA, 1'b0);
        offer(1'b1, 64'hB, 1'b0);
        offer(1'b1, 64'hC, 1'b0);
        offer(1'b1, 64'hC, 1'b0);
        offer(1'b1, 64'hC, 1'b1);   // pop A
        offer(1'b1, 64'hC, 1'b1);   // push C, pop B
        offer(1'b0, 64'h0, 1'b1);   // pop C
        step(2);

        // Simultaneous push and pop at count 1.
        offer(1'b1, 64'h11, 1'b0);
        offer(1'b1, 64'h22, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_count", DW'(count), 64'd1);
        chk("pushpop_data", out_data, 64'h22);
        offer(1'b0, 64'h0, 1'b1);
        step();

        // Flush while full with D offered.
        offer(1'b1, 64'hAA, 1'b0);
        offer(1'b1, 64'hBB, 1'b0);
        flush = 1'b1;
        offer(1'b1, 64'hDD, 1'b0);
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", DW'(count), FE ? 64'd0 : 64'd2);
        chk("flush_in_ready", DW'(in_ready), FE ? 64'd1 : 64'd0);
        offer(1'b0, 64'h0, 1'b1);
        step(3);

        // Reset mid-operation while full.
        offer(1'b1, 64'h5A, 1'b0);
        offer(1'b1, 64'h5B, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_in_ready", DW'(in_ready), '0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", DW'(out_valid), '0);
        chk("post_rst_out_data", out_data, '0);
        chk("post_rst_count", DW'(count), '0);
        chk("post_rst_in_ready", DW'(in_ready), 64'd1);
        step();

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            if (!(in_valid && !acc)) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = {$urandom, $urandom};
            end
            out_ready = ($urandom % 3) != 0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(4);
        @(negedge clk);
        chk("drained", DW'(q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
# if_id_skid

Two-entry elastic pipeline buffer between instruction fetch and decode. Carries a DW-bit payload (fetch PC and instruction word packed by the fetch stage) under a valid/ready handshake. Sustains one transfer per cycle while fully registering the backward `in_ready` path, so decode back-pressure never reaches fetch combinationally. Decode consumes `out_data` and loads its own enabled flops from it.

## Interface
Parameters:
- `DW`, 64, payload width in bits (32-bit PC plus 32-bit instruction).

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `flush`  input  1  discard all buffered entries (branch or trap redirect).
- `in_valid`  input  1  fetch presents a payload.
- `in_ready`  output  1  buffer accepts a payload this cycle.
- `in_data`  input  DW  payload from fetch.
- `out_valid`  output  1  head entry is valid.
- `out_ready`  input  1  decode takes the head entry this cycle.
- `out_data`  output  DW  head entry payload.
- `count`  output  2  occupancy: 0, 1 or 2.

## Operation
- Storage:
  - Two entries `mem[0..1]`.
  - 1-bit `wr_ptr` and `rd_ptr`, each wrapping 1→0.
  - 2-bit `count`; its values are the states EMPTY=0, ONE=1, FULL=2.
- Handshake:
  - push = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
- Outputs:
  - `in_ready` = (count != 2) & ~rst.
  - `out_valid` = (count != 0).
  - `out_data` = mem[rd_ptr].
  - All are driven from registers and pointers only. There is no combinational path from `in_*` to `out_*`, and none from `out_ready` to `in_ready`.
- State transitions when flush is not active:
  - EMPTY + push → ONE.
  - ONE + push, no pop → FULL.
  - ONE + pop, no push → EMPTY.
  - ONE + push + pop → ONE; the new entry becomes head next cycle.
  - FULL + pop → ONE.
  - FULL with `in_valid` high: no push, because `in_ready` is 0.
  - No push and no pop: hold.
- Push writes `mem[wr_ptr]` ← `in_data`, then advances `wr_ptr`. Pop advances `rd_ptr`. Both may occur in the same cycle.
- Flush (when compiled in):
  - Next state is count=0 and `wr_ptr`=`rd_ptr`=0.
  - Overrides push and pop in that cycle; a payload offered in the flush cycle is dropped.
  - Memory contents are not cleared.
- Reset:
  - All registers go to 0: count, both pointers, and both mem entries.
  - Reset outputs: `out_valid`=0, `out_data`=0, `count`=0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
  - Reset mid-operation discards all entries, with the same effect as flush.
  - Reset has priority over flush.
- Producer rule: once `in_valid` is asserted, `in_data` holds until accepted. The bench checks this; the RTL does not.

## Timing
- Latency: a payload pushed at edge N is visible on `out_valid`/`out_data` after edge N (the cycle following acceptance). Minimum latency is 1 cycle.
- Throughput: 1 payload/cycle sustained when `out_ready` stays high.
- Back-pressure:
  - `out_ready` low for k cycles lets at most 2 payloads accumulate.
  - `in_ready` falls the cycle after count reaches 2.
  - `in_ready` rises the cycle after the first pop from FULL.
- Flush asserted at edge N: `out_valid`=0 and `in_ready`=1 after edge N.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `RISCX_SKID_FLUSH_EN`:
  - Defined: `flush` behaves as described above.
  - Undefined: the `flush` port remains present but is ignored. Entries are discarded only by `rst`, and logic and timing are otherwise identical.

## Test plan
- Reset release, then 3 payloads 0x1000_0001, 0x1000_0002, 0x1000_0003 pushed on back-to-back cycles with `out_ready`=1 → `out_data` shows them in order on consecutive cycles starting 1 cycle after each push; `count` stays 1; `in_ready` stays 1.
- `out_ready`=0, push A then B → `count`=2 and `in_ready`=0 after the second push. Offering C while full is not accepted. Raise `out_ready` → outputs A, then B, then C, with `in_ready` back to 1 one cycle after the A pop.
- Count=1 holding A, simultaneous push B and pop A → `count` stays 1 and `out_data`=B next cycle.
- Count=2, flush asserted together with `in_valid`/D → next cycle `count`=0, `out_valid`=0, `in_ready`=1, and D is never output. With `RISCX_SKID_FLUSH_EN` undefined, the same stimulus leaves `count`=2.
- `rst` held 1 cycle while count=2 → `out_valid`=0, `out_data`=0 and `count`=0 afterward; `in_ready`=0 during the reset cycle and 1 in the next.
- Random `in_valid`/`out_ready` for 10,000 cycles against a queue model → no loss, duplication or reordering, and `count` never exceeds 2.
